// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplier-sharing arbiter.
// Holds the FSM state encoding, the default datapath width and index sizing.
package mul_share_arbiter_pkg;

  localparam int DEF_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Bits needed to index n requesters; never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Returns a one-hot grant, its index and an any-hit flag.
module mul_share_arbiter_rr_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Scan from the pointer; the first hit masks all later candidates.
  always_comb begin
    int   cand;
    logic hit_s;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand      = int'(ptr) + k;
      cand      = (cand >= NREQ) ? (cand - NREQ) : cand;
      hit_s     = ~any & req[cand];
      gnt[cand] = gnt[cand] | hit_s;
      idx       = hit_s ? IDXW'(cand) : idx;
      any       = any | hit_s;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential multiplier between NREQ requesters in round-robin order,
// routes each result back to its owner and aborts operations that hang.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       resp_valid,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [WIDTH-1:0]      mul_result,
  input  logic                  mul_done
);

  localparam int IDXW = idx_width(NREQ);
  localparam int TW   = $clog2(TIMEOUT) + 1;

  state_t            state_r, state_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic [NREQ-1:0]   resp_valid_r, resp_valid_s;
  logic              resp_err_r, resp_err_s;
  logic [WIDTH-1:0]  resp_data_r, resp_data_s;
  logic              mul_start_r, mul_start_s;
  logic [WIDTH-1:0]  mul_a_r, mul_a_s;
  logic [WIDTH-1:0]  mul_b_r, mul_b_s;
  logic [IDXW-1:0]   ptr_r, ptr_s;
  logic [IDXW-1:0]   owner_r, owner_s;
  logic [TW-1:0]     wdog_r, wdog_s;

  logic [NREQ-1:0]   arb_gnt_s;
  logic [IDXW-1:0]   arb_idx_s;
  logic              arb_any_s;
  logic              wdog_expired_s;

  mul_share_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req (req),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  assign wdog_expired_s = (wdog_r == TW'(TIMEOUT - 1));

  // Next-state, operand capture, watchdog and response decisions.
  always_comb begin
    state_s      = state_r;
    gnt_s        = gnt_r;
    resp_valid_s = '0;
    resp_err_s   = resp_err_r;
    resp_data_s  = resp_data_r;
    mul_start_s  = 1'b0;
    mul_a_s      = mul_a_r;
    mul_b_s      = mul_b_r;
    ptr_s        = ptr_r;
    owner_s      = owner_r;
    wdog_s       = wdog_r;
    case (state_r)
      IDLE: begin
        if (arb_any_s) begin
          gnt_s       = arb_gnt_s;
          owner_s     = arb_idx_s;
          mul_a_s     = a_in[int'(arb_idx_s)*WIDTH +: WIDTH];
          mul_b_s     = b_in[int'(arb_idx_s)*WIDTH +: WIDTH];
          mul_start_s = 1'b1;
          state_s     = ISSUE;
        end else begin
          state_s     = IDLE;
        end
      end
      ISSUE: begin
        wdog_s  = '0;
        state_s = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A done still high from the previous operation is not ours.
        if (wdog_expired_s) begin
          resp_data_s  = '0;
          resp_err_s   = 1'b1;
          resp_valid_s = gnt_r;
          state_s      = RESP;
        end else if (!mul_done) begin
          wdog_s  = wdog_r + TW'(1);
          state_s = WAIT_DONE;
        end else begin
          wdog_s  = wdog_r + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (mul_done) begin
          resp_data_s  = mul_result;
          resp_err_s   = 1'b0;
          resp_valid_s = gnt_r;
          state_s      = RESP;
        end else if (wdog_expired_s) begin
          resp_data_s  = '0;
          resp_err_s   = 1'b1;
          resp_valid_s = gnt_r;
          state_s      = RESP;
        end else begin
          wdog_s = wdog_r + TW'(1);
        end
      end
      RESP: begin
        gnt_s   = '0;
        ptr_s   = (owner_r == IDXW'(NREQ - 1)) ? '0 : (owner_r + IDXW'(1));
        state_s = IDLE;
      end
      default: begin
        gnt_s   = '0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      gnt_r        <= '0;
      resp_valid_r <= '0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= '0;
      mul_start_r  <= 1'b0;
      mul_a_r      <= '0;
      mul_b_r      <= '0;
      ptr_r        <= '0;
      owner_r      <= '0;
      wdog_r       <= '0;
    end else begin
      state_r      <= state_s;
      gnt_r        <= gnt_s;
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_data_r  <= resp_data_s;
      mul_start_r  <= mul_start_s;
      mul_a_r      <= mul_a_s;
      mul_b_r      <= mul_b_s;
      ptr_r        <= ptr_s;
      owner_r      <= owner_s;
      wdog_r       <= wdog_s;
    end
  end

  assign gnt        = gnt_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_data  = resp_data_r;
  assign mul_start  = mul_start_r;
  assign mul_a      = mul_a_r;
  assign mul_b      = mul_b_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a 5-cycle stub multiplier whose
// done stays high until the next start (optionally for a few cycles past it).
module tb_mul_share_arbiter;

  localparam int WIDTH   = 24;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [WIDTH-1:0]      a0, a1, b0, b1;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [NREQ-1:0]       gnt, resp_valid;
  logic                  resp_err, mul_start;
  logic [WIDTH-1:0]      resp_data, mul_a, mul_b;

  logic                  stub_done = 1'b0;
  logic [WIDTH-1:0]      stub_res  = '0;
  logic [2*WIDTH-1:0]    stub_prod;
  int                    busy = 0;
  int                    hold = 0;
  int                    sticky_hold = 0;
  bit                    hang = 1'b0;
  int                    start_cnt = 0;

  int checks   = 0;
  int failures = 0;

  assign a_in      = {a1, a0};
  assign b_in      = {b1, b0};
  assign stub_prod = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_data  (resp_data),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (stub_res),
    .mul_done   (stub_done)
  );

  // Stub multiplier: done rises 5 edges after start is sampled, stays high until the next start.
  always @(posedge clk) begin
    if (mul_start) begin
      start_cnt <= start_cnt + 1;
      busy      <= 5;
      hold      <= sticky_hold;
      if (sticky_hold == 0) stub_done <= 1'b0;
    end else begin
      if (hold > 0) begin
        hold <= hold - 1;
        if (hold == 1) stub_done <= 1'b0;
      end
      if (busy > 0 && !hang) begin
        busy <= busy - 1;
        if (busy == 1) begin
          stub_done <= 1'b1;
          stub_res  <= stub_prod[WIDTH-1:0];
        end
      end
    end
  end

  // Waits up to budget edges for resp_valid; n counts edges from the call.
  task automatic wait_resp(input int budget, output logic [NREQ-1:0] rv, output logic err,
                           output logic [WIDTH-1:0] data, output int n);
    rv = '0; err = 1'b0; data = '0; n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (resp_valid != '0) begin
        rv = resp_valid; err = resp_err; data = resp_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [NREQ-1:0]  rv;
    logic             err;
    logic [WIDTH-1:0] data;
    int               n;
    rst = 1'b0; req = 2'b11;
    a0 = 24'd2; b0 = 24'd7; a1 = 24'd4; b1 = 24'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({gnt, resp_valid, resp_err, mul_start} !== 6'b0) begin
        failures++;
        $display("FAIL reset_ctrl: got gnt=%b rv=%b err=%b start=%b expected all 0",
                 gnt, resp_valid, resp_err, mul_start);
      end
      checks++;
      if (mul_a !== 24'd0 || mul_b !== 24'd0 || resp_data !== 24'd0 || start_cnt !== 0) begin
        failures++;
        $display("FAIL reset_data: got a=%0d b=%0d data=%0d starts=%0d expected 0",
                 mul_a, mul_b, resp_data, start_cnt);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b01 || mul_a !== 24'd2 || mul_b !== 24'd7) begin
      failures++;
      $display("FAIL reset_first_gnt: got gnt=%b a=%0d b=%0d expected gnt=01 a=2 b=7", gnt, mul_a, mul_b);
    end
    // Requester drops req while granted: the response must still arrive.
    req = 2'b00;
    wait_resp(40, rv, err, data, n);
    checks++;
    if (rv !== 2'b01 || err !== 1'b0 || data !== 24'd14) begin
      failures++;
      $display("FAIL dropped_req_resp: got rv=%b err=%b data=%0d expected rv=01 err=0 data=14", rv, err, data);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0]  rv;
    logic             err;
    logic [WIDTH-1:0] data;
    int               n, s0;
    @(posedge clk); #1;
    s0 = start_cnt;
    a1 = 24'd3; b1 = 24'd5; req = 2'b10;
    // req raised in cycle 1, resp_valid high in cycle 9 (8th edge)
    wait_resp(40, rv, err, data, n);
    req = 2'b00;
    checks++;
    if (rv !== 2'b10 || err !== 1'b0 || data !== 24'd15) begin
      failures++;
      $display("FAIL single_resp: got rv=%b err=%b data=%0d expected rv=10 err=0 data=15", rv, err, data);
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL single_latency: got %0d edges expected 8", n);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL single_starts: got %0d start pulses expected 1", start_cnt - s0);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 2'b00 || gnt !== 2'b00) begin
      failures++;
      $display("FAIL single_pulse: got rv=%b gnt=%b expected 00 00", resp_valid, gnt);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0]  rv, exp_rv;
    logic             err;
    logic [WIDTH-1:0] data, exp_data;
    int               n;
    a0 = 24'd2; b0 = 24'd7; a1 = 24'd4; b1 = 24'd4; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_rv   = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (i % 2 == 0) ? 24'd14 : 24'd16;
      wait_resp(40, rv, err, data, n);
      checks++;
      if (rv !== exp_rv || err !== 1'b0 || data !== exp_data) begin
        failures++;
        $display("FAIL contention_op%0d: got rv=%b err=%b data=%0d expected rv=%b err=0 data=%0d",
                 i, rv, err, data, exp_rv, exp_data);
      end
    end
    req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_sticky_done();
    logic [NREQ-1:0]  rv;
    logic             err;
    logic [WIDTH-1:0] data;
    int               n;
    // done is still high from the last op (result 16) and lingers 2 edges past start
    sticky_hold = 2;
    a0 = 24'd9; b0 = 24'd10; req = 2'b01;
    wait_resp(40, rv, err, data, n);
    req = 2'b00;
    sticky_hold = 0;
    checks++;
    if (rv !== 2'b01 || err !== 1'b0 || data !== 24'd90) begin
      failures++;
      $display("FAIL sticky_resp: got rv=%b err=%b data=%0d expected rv=01 err=0 data=90", rv, err, data);
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL sticky_latency: got %0d edges expected 8", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hang();
    logic [NREQ-1:0]  rv;
    logic             err;
    logic [WIDTH-1:0] data;
    int               n;
    hang = 1'b1;
    a1 = 24'd7; b1 = 24'd7; req = 2'b10;
    wait_resp(200, rv, err, data, n);
    req = 2'b00;
    hang = 1'b0;
    checks++;
    if (rv !== 2'b10 || err !== 1'b1 || data !== 24'd0) begin
      failures++;
      $display("FAIL hang_resp: got rv=%b err=%b data=%0d expected rv=10 err=1 data=0", rv, err, data);
    end
    // arbitrate + issue + TIMEOUT wait cycles, response on the following edge
    checks++;
    if (n !== TIMEOUT + 2) begin
      failures++;
      $display("FAIL hang_latency: got %0d edges expected %0d", n, TIMEOUT + 2);
    end
    @(posedge clk); #1;
    a0 = 24'hFFFFFF; b0 = 24'd2; req = 2'b01;
    wait_resp(40, rv, err, data, n);
    req = 2'b00;
    checks++;
    if (rv !== 2'b01 || err !== 1'b0 || data !== 24'hFFFFFE) begin
      failures++;
      $display("FAIL after_hang_resp: got rv=%b err=%b data=%h expected rv=01 err=0 data=fffffe", rv, err, data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    logic [NREQ-1:0]  rv;
    logic             err;
    logic [WIDTH-1:0] data;
    int               n, seen, s0;
    a1 = 24'd5; b1 = 24'd6; req = 2'b10;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 2'b10 || mul_a !== 24'd5 || mul_b !== 24'd6) begin
      failures++;
      $display("FAIL midop_hold: got gnt=%b a=%0d b=%0d expected gnt=10 a=5 b=6", gnt, mul_a, mul_b);
    end
    rst = 1'b0; req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 2'b00 || gnt !== 2'b00 || mul_start !== 1'b0 || mul_a !== 24'd0) begin
      failures++;
      $display("FAIL midop_reset: got rv=%b gnt=%b start=%b a=%0d expected all 0",
               resp_valid, gnt, mul_start, mul_a);
    end
    rst = 1'b1;
    seen = 0; s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 2'b00) seen++;
    end
    checks++;
    if (seen !== 0 || start_cnt !== s0) begin
      failures++;
      $display("FAIL midop_no_resp: got %0d responses %0d starts expected 0 0", seen, start_cnt - s0);
    end
    a0 = 24'd2; b0 = 24'd7; req = 2'b11;
    wait_resp(40, rv, err, data, n);
    req = 2'b00;
    checks++;
    if (rv !== 2'b01 || err !== 1'b0 || data !== 24'd14) begin
      failures++;
      $display("FAIL midop_ptr_reset: got rv=%b err=%b data=%0d expected rv=01 err=0 data=14", rv, err, data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_sticky_done();
    test_hang();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one sequential 24-bit multiplier between NREQ requesters using a round-robin scheme.
- Drives the multiplier's start/operand interface (startMul, A, B) and collects its result on doneMul.
- Returns each result to the requester that owns the operation.
- Includes a watchdog that aborts an operation if the multiplier hangs.

Parameters:
- WIDTH, 24, operand/result width; must match the multiplier datapath.
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 64, cycles allowed from start to done before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*WIDTH  flattened operand A; slice i belongs to requester i.
- b_in  in  NREQ*WIDTH  flattened operand B; slice i belongs to requester i.
- gnt  out  NREQ  one-hot; the owner of the in-flight operation.
- resp_valid  out  NREQ  one-cycle pulse to the owner when its result or abort is ready.
- resp_err  out  1  valid with resp_valid; 1 = watchdog abort.
- resp_data  out  WIDTH  result, valid with resp_valid.
- mul_start  out  1  to the multiplier's startMul.
- mul_a  out  WIDTH  to the multiplier's A.
- mul_b  out  WIDTH  to the multiplier's B.
- mul_result  in  WIDTH  from the multiplier's result.
- mul_done  in  1  from the multiplier's doneMul; treated as a level that may stay high after completion.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State = IDLE; gnt, resp_valid, resp_err, mul_start = 0; resp_data, mul_a, mul_b = 0.
  - Round-robin pointer = 0 (requester 0 has highest priority).
  - Watchdog = 0.
  - Reset mid-operation abandons the operation immediately; no response is issued; the multiplier is not told.
- IDLE:
  - If any req is high: pick the first asserted requester at or after the pointer, wrapping modulo NREQ.
  - Register gnt, and latch that requester's operands into mul_a/mul_b.
  - Go to ISSUE.
  - Arbitration takes 1 cycle.
- ISSUE: mul_start=1 for exactly one cycle; watchdog cleared; go to WAIT_LOW.
- WAIT_LOW:
  - Wait until mul_done=0 has been seen at least once. This guards against a sticky done left over from the previous operation.
  - Then go to WAIT_DONE.
- WAIT_DONE:
  - On the first edge with mul_done=1: capture resp_data=mul_result, resp_err=0, go to RESP.
- Watchdog:
  - Counts every cycle in WAIT_LOW and WAIT_DONE.
  - When it reaches TIMEOUT-1 with no done: resp_data=0, resp_err=1, go to RESP.
  - If done and timeout occur on the same edge, done wins.
- RESP:
  - resp_valid[owner]=1 for one cycle.
  - Pointer = owner+1 (wraps to 0 after NREQ-1).
  - gnt cleared.
  - Go to IDLE.
- Latency and throughput:
  - Minimum latency from req high to resp_valid is 4 + multiplier latency cycles.
  - Back-to-back grants are possible: the next IDLE cycle re-arbitrates.
- mul_a and mul_b hold their values from grant through RESP.
- Requester contract:
  - Holds req and operands stable until its resp_valid.
  - Drops req in the following cycle, or it is treated as a new request.
- A req deasserted while granted is ignored: the operation completes and the response is still pulsed.
- Simultaneous requests are resolved solely by the pointer; no requester waits more than NREQ-1 operations.
- Unused slices of a_in/b_in are don't-care.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE=0, ISSUE=1, WAIT_LOW=2, WAIT_DONE=3, RESP=4 (3 bits).
  - Default WIDTH=24.
- Sub-module rr_arbiter (combinational), called from the top:
  - Inputs: req, pointer.
  - Output: one-hot grant and its index.
- FSM, operand muxing, watchdog and response registers live in mul_share_arbiter.

Test Plan:
The bench uses a stub multiplier with 5-cycle latency that returns the low 24 bits of A*B, with doneMul held high until the next start.
- Reset hold: rst=0 for 3 cycles while req=2'b11 -> all outputs 0 and no mul_start; after rst=1, gnt=2'b01 on the next edge.
- Single request: req[1]=1, a=3, b=5 -> exactly one mul_start pulse; resp_valid=2'b10 with resp_data=15 and resp_err=0, 9 cycles after req.
- Contention: both requesters always request (0: 2*7, 1: 4*4) -> grants alternate 0,1,0,1; results 14 and 16; no requester serviced twice in a row.
- Sticky done: done is still high from the previous op when the next op is issued -> that op is not completed until done falls and rises again; its result is correct.
- Hang: stub never asserts done -> resp_valid with resp_err=1 and resp_data=0 after TIMEOUT cycles in WAIT states; the next request is served normally.
- Reset mid-operation: rst=0 during WAIT_DONE -> no resp_valid is issued; after release, the pointer is 0 and requester 0 wins over requester 1.
